// File: rtl/bit_err_pkg.sv
// bit_err_counter shared types: FSM state encoding and default widths.
// Optional first-error capture is enabled by BIT_ERR_FIRST_IDX_EN.
package bit_err_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int DEF_WIN_W = 16;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// The flag sets on the first increment attempted while already at max.
module sat_counter
  import bit_err_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr_in,
  input  logic         inc_in,
  output logic [W-1:0] cnt_out,
  output logic         sat_out
);

  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic         w_max;

  assign w_max = (r_cnt == {W{1'b1}});

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc_in) begin
      if (w_max) r_sat <= 1'b1;
      else       r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_out = r_cnt;
  assign sat_out = r_sat;

endmodule

// File: rtl/bit_err_counter.sv
// Windowed bit-error counter with valid/ready result handshake.
// Define BIT_ERR_FIRST_IDX_EN to add first-error index capture.
module bit_err_counter
  import bit_err_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIN_W-1:0] win_len_in,
  input  logic             err_valid_in,
  input  logic             err_in,
  output logic             busy_out,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [CNT_W-1:0] err_cnt_out,
  output logic             sat_out
`ifdef BIT_ERR_FIRST_IDX_EN
  ,
  output logic             first_err_vld_out,
  output logic [WIN_W-1:0] first_err_idx_out
`endif
);

  state_t           r_state;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W-1:0] r_idx;
  logic             r_busy;
  logic             r_res_valid;

  logic             w_start;
  logic             w_consume;
  logic             w_err;
  logic [WIN_W-1:0] w_idx_nxt;
  logic             w_last;
  logic             w_hs;

  assign w_start   = (r_state == IDLE) && start_in;
  assign w_consume = (r_state == COUNT) && err_valid_in;
  assign w_err     = w_consume && err_in;
  assign w_idx_nxt = r_idx + WIN_W'(1);
  assign w_last    = w_consume && (w_idx_nxt == r_len);
  assign w_hs      = (r_state == RESULT) && res_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len  <= win_len_in;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (win_len_in == '0) begin
              r_state     <= RESULT;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (w_consume) r_idx <= w_idx_nxt;
          if (w_last) begin
            r_state     <= RESULT;
            r_res_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (w_hs) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (w_start),
    .inc_in  (w_err),
    .cnt_out (err_cnt_out),
    .sat_out (sat_out)
  );

  assign busy_out      = r_busy;
  assign res_valid_out = r_res_valid;

`ifdef BIT_ERR_FIRST_IDX_EN
  logic             r_first_vld;
  logic [WIN_W-1:0] r_first_idx;

  // r_idx is the 0-based index of the bit being consumed this cycle
  always_ff @(posedge clk_in) begin
    if (rst_in || w_start) begin
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else if (w_err && !r_first_vld) begin
      r_first_vld <= 1'b1;
      r_first_idx <= r_idx;
    end
  end

  assign first_err_vld_out = r_first_vld;
  assign first_err_idx_out = r_first_idx;
`endif

endmodule
